// File: rtl/led_pattern_master.sv
// LED pattern master: on each timer tick it writes the next LED pattern to
// PIO address 0, reads it back, and records any readback mismatch.
module led_pattern_master #(
  parameter int PERIOD = 1000000,
  parameter int WIDTH  = 18
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] pattern_in,
  output logic [1:0]       avm_address,
  output logic             avm_chipselect,
  output logic             avm_write_n,
  output logic [31:0]      avm_writedata,
  input  logic [31:0]      avm_readdata,
  input  logic             avm_waitrequest,
  output logic             busy,
  output logic [WIDTH-1:0] pattern,
  output logic             mismatch,
  output logic [7:0]       mismatch_count
);

  localparam int TW = (PERIOD > 2) ? $clog2(PERIOD) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(PERIOD - 1);

  typedef enum logic [1:0] {IDLE, WRITE, READ, CHECK} state_t;

  state_t           state_q, state_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic [WIDTH-1:0] pattern_q, pattern_d;
  logic [WIDTH-1:0] rd_q, rd_d;
  logic             mismatch_q, mismatch_d;
  logic [7:0]       mcount_q, mcount_d;
  logic             busy_q, busy_d;
  logic [WIDTH-1:0] next_pattern;
  logic             tick;

  // The PIO only implements the low WIDTH bits; the rest of readdata is don't-care.
  logic unused_readdata_hi;
  assign unused_readdata_hi = ^avm_readdata[31:WIDTH];

  // Tick fires on the last count of the interval, only while idle and enabled.
  always_comb begin
    tick = enable && (state_q == IDLE) && (timer_q == TIMER_LAST);
  end

  // Interval timer: runs only in IDLE, cleared while paused, wraps on tick.
  always_comb begin
    timer_d = timer_q;
    if (!enable) begin
      timer_d = '0;
    end else if (state_q == IDLE) begin
      timer_d = tick ? '0 : timer_q + TW'(1);
    end
  end

  // Candidate pattern for the next update, selected by the current mode.
  always_comb begin
    next_pattern = pattern_q;
    case (mode)
      2'd0: next_pattern = pattern_q + WIDTH'(1);
      2'd1: begin
        if (pattern_q == '0) begin
          next_pattern = WIDTH'(1);
        end else begin
          next_pattern = {pattern_q[WIDTH-2:0], pattern_q[WIDTH-1]};
        end
      end
      2'd2: next_pattern = pattern_in;
      default: next_pattern = pattern_q;
    endcase
  end

  // Transaction sequencer: write, read back, compare, then back to idle.
  always_comb begin
    state_d    = state_q;
    pattern_d  = pattern_q;
    rd_d       = rd_q;
    mismatch_d = mismatch_q;
    mcount_d   = mcount_q;
    unique case (state_q)
      IDLE: begin
        if (tick) begin
          pattern_d = next_pattern;
          state_d   = WRITE;
        end
      end
      WRITE: begin
        if (!avm_waitrequest) begin
          state_d = READ;
        end
      end
      READ: begin
        if (!avm_waitrequest) begin
          rd_d    = avm_readdata[WIDTH-1:0];
          state_d = CHECK;
        end
      end
      CHECK: begin
        if (rd_q != pattern_q) begin
          mismatch_d = 1'b1;
          if (mcount_q != 8'hFF) begin
            mcount_d = mcount_q + 8'd1;
          end
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      timer_q    <= '0;
      pattern_q  <= '0;
      rd_q       <= '0;
      mismatch_q <= 1'b0;
      mcount_q   <= 8'd0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      pattern_q  <= pattern_d;
      rd_q       <= rd_d;
      mismatch_q <= mismatch_d;
      mcount_q   <= mcount_d;
      busy_q     <= busy_d;
    end
  end

  // Bus outputs decode from registered state, so they stay stable during stalls.
  always_comb begin
    avm_address                = 2'd0;
    avm_chipselect             = (state_q == WRITE) || (state_q == READ);
    avm_write_n                = (state_q != WRITE);
    avm_writedata              = '0;
    avm_writedata[WIDTH-1:0]   = pattern_q;
  end

  assign busy           = busy_q;
  assign pattern        = pattern_q;
  assign mismatch       = mismatch_q;
  assign mismatch_count = mcount_q;

endmodule

// File: tb/tb_led_pattern_master.sv
// Testbench for led_pattern_master: PIO slave model with configurable stalls
// and readback fault, plus a behavioural pattern model.
module tb_led_pattern_master;

  localparam int PERIOD = 4;
  localparam int WIDTH  = 18;
  localparam int LOGN   = 1024;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic [17:0] pattern_in = '0;
  logic [1:0]  avm_address;
  logic        avm_chipselect;
  logic        avm_write_n;
  logic [31:0] avm_writedata;
  logic [31:0] avm_readdata;
  logic        avm_waitrequest;
  logic        busy;
  logic [17:0] pattern;
  logic        mismatch;
  logic [7:0]  mismatch_count;

  int total = 0;
  int bad = 0;

  // Slave model configuration and bus monitor state
  int          wcfg = 0;
  int          rcfg = 0;
  int          stall_cnt = 0;
  logic        fault = 1'b0;
  logic [13:0] hi_junk = '0;
  logic [17:0] pio_reg = '0;
  logic [31:0] wr_log [0:LOGN-1];
  int          wr_cyc [0:LOGN-1];
  int          wr_n = 0;
  int          rd_n = 0;
  int          cyc = 0;
  int          rel = 0;

  led_pattern_master #(.PERIOD(PERIOD), .WIDTH(WIDTH)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .mode(mode),
    .pattern_in(pattern_in), .avm_address(avm_address),
    .avm_chipselect(avm_chipselect), .avm_write_n(avm_write_n),
    .avm_writedata(avm_writedata), .avm_readdata(avm_readdata),
    .avm_waitrequest(avm_waitrequest), .busy(busy), .pattern(pattern),
    .mismatch(mismatch), .mismatch_count(mismatch_count)
  );

  always #5 clk = ~clk;

  // Stall the current transfer for wcfg/rcfg cycles before accepting it.
  assign avm_waitrequest = avm_chipselect &&
                           (avm_write_n ? (stall_cnt < rcfg) : (stall_cnt < wcfg));
  assign avm_readdata = {hi_junk, fault ? (pio_reg & ~18'h00020) : pio_reg};

  // PIO register and accept-level bus log.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (avm_chipselect && avm_waitrequest) stall_cnt <= stall_cnt + 1;
    else stall_cnt <= 0;
    if (avm_chipselect && !avm_waitrequest) begin
      if (!avm_write_n) begin
        pio_reg <= avm_writedata[17:0];
        if (wr_n < LOGN) begin
          wr_log[wr_n] <= avm_writedata;
          wr_cyc[wr_n] <= cyc;
        end
        wr_n <= wr_n + 1;
      end else begin
        rd_n <= rd_n + 1;
      end
    end
  end

  // Reference for the next pattern, written as plain integer arithmetic.
  function automatic int next_pat(input int m, input int p, input int pin);
    case (m)
      0: return (p + 1) % 262144;
      1: return (p == 0) ? 1 : ((p * 2) % 262144) + (p / 131072);
      2: return pin % 262144;
      default: return p;
    endcase
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    rel = cyc;
  endtask

  task automatic wait_writes(input int target, input int budget, input string name);
    int i;
    i = 0;
    while (wr_n < target && i < budget) begin
      @(negedge clk);
      i++;
    end
    total++;
    if (wr_n < target) begin
      bad++;
      $display("[TB] FAIL %s timeout: writes=%0d expected %0d", name, wr_n, target);
    end
  endtask

  task automatic wait_idle(input int budget, input string name);
    int i;
    i = 0;
    @(negedge clk);
    while (busy !== 1'b0 && i < budget) begin
      @(negedge clk);
      i++;
    end
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("[TB] FAIL %s idle timeout: busy=%b expected 0", name, busy);
    end
  endtask

  task automatic test_reset();
    enable = 1'b1;
    mode = 2'($urandom_range(0, 3));
    pattern_in = 18'($urandom);
    @(negedge clk);
    reset_n = 1'b0;
    repeat (10) @(negedge clk);
    total++; if (avm_chipselect !== 1'b0) begin bad++; $display("[TB] FAIL reset_cs: got %b expected 0", avm_chipselect); end
    total++; if (avm_write_n !== 1'b1) begin bad++; $display("[TB] FAIL reset_write_n: got %b expected 1", avm_write_n); end
    total++; if (avm_address !== 2'd0) begin bad++; $display("[TB] FAIL reset_addr: got %0h expected 0", avm_address); end
    total++; if (avm_writedata !== 32'd0) begin bad++; $display("[TB] FAIL reset_wdata: got %0h expected 0", avm_writedata); end
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    total++; if (pattern !== 18'd0) begin bad++; $display("[TB] FAIL reset_pattern: got %0h expected 0", pattern); end
    total++; if (mismatch !== 1'b0) begin bad++; $display("[TB] FAIL reset_mismatch: got %b expected 0", mismatch); end
    total++; if (mismatch_count !== 8'd0) begin bad++; $display("[TB] FAIL reset_mcount: got %0d expected 0", mismatch_count); end
  endtask

  task automatic test_count();
    int base;
    int p;
    logic [31:0] exp32;
    wcfg = 0; rcfg = 0; fault = 1'b0;
    mode = 2'd0; enable = 1'b1;
    do_reset();
    base = wr_n;
    p = 0;
    wait_writes(base + 3, 60, "count");
    total++; if (busy !== 1'b1) begin bad++; $display("[TB] FAIL count_busy: got %b expected 1", busy); end
    for (int k = 0; k < 3; k++) begin
      p = next_pat(0, p, 0);
      exp32 = 32'(p);
      total++;
      if (wr_log[base + k] !== exp32) begin
        bad++; $display("[TB] FAIL count_val%0d: got %0h expected %0h", k, wr_log[base + k], exp32);
      end
    end
    total++;
    if (wr_cyc[base] !== rel + PERIOD) begin
      bad++; $display("[TB] FAIL count_first_latency: got %0d expected %0d", wr_cyc[base] - rel, PERIOD);
    end
    for (int k = 1; k < 3; k++) begin
      total++;
      if (wr_cyc[base + k] - wr_cyc[base + k - 1] !== PERIOD + 3) begin
        bad++; $display("[TB] FAIL count_spacing%0d: got %0d expected %0d", k, wr_cyc[base + k] - wr_cyc[base + k - 1], PERIOD + 3);
      end
    end
    wait_idle(10, "count");
    total++; if (pattern !== 18'(p)) begin bad++; $display("[TB] FAIL count_pattern: got %0h expected %0h", pattern, p); end
    total++; if (mismatch !== 1'b0) begin bad++; $display("[TB] FAIL count_mismatch: got %b expected 0", mismatch); end
  endtask

  task automatic test_wrap();
    int base;
    mode = 2'd2; pattern_in = 18'h3FFFF;
    base = wr_n;
    wait_writes(base + 1, 20, "wrap_load");
    mode = 2'd0;
    total++; if (wr_log[base] !== 32'h0003FFFF) begin bad++; $display("[TB] FAIL wrap_load: got %0h expected 3ffff", wr_log[base]); end
    wait_writes(base + 2, 20, "wrap");
    total++;
    if (wr_log[base + 1] !== 32'(next_pat(0, 262143, 0))) begin
      bad++; $display("[TB] FAIL wrap_value: got %0h expected 0", wr_log[base + 1]);
    end
    wait_idle(10, "wrap");
    total++; if (pattern !== 18'd0) begin bad++; $display("[TB] FAIL wrap_pattern: got %0h expected 0", pattern); end
  endtask

  task automatic test_walk();
    int base;
    int p;
    mode = 2'd1; enable = 1'b1;
    do_reset();
    base = wr_n;
    p = 0;
    wait_writes(base + 19, 19 * (PERIOD + 3) + 20, "walk");
    for (int k = 0; k < 19; k++) begin
      p = next_pat(1, p, 0);
      total++;
      if (wr_log[base + k] !== 32'(p)) begin
        bad++; $display("[TB] FAIL walk%0d: got %0h expected %0h", k, wr_log[base + k], p);
      end
    end
  endtask

  task automatic test_waitrequest();
    int base_w;
    int base_r;
    int wcycles;
    int rcycles;
    int i;
    logic [17:0] pin;
    logic [31:0] exp32;
    pin = 18'($urandom);
    exp32 = 32'(pin);
    mode = 2'd2; pattern_in = pin; enable = 1'b1;
    wcfg = 0; rcfg = 0;
    do_reset();
    wcfg = 3; rcfg = 2;
    base_w = wr_n; base_r = rd_n;
    i = 0;
    while (!(avm_chipselect === 1'b1 && avm_write_n === 1'b0) && i < 30) begin
      @(negedge clk);
      i++;
    end
    total++;
    if (!(avm_chipselect === 1'b1 && avm_write_n === 1'b0)) begin
      bad++; $display("[TB] FAIL wait_start timeout: cs=%b write_n=%b expected 1/0", avm_chipselect, avm_write_n);
    end
    enable = 1'b0;
    wcycles = 0; rcycles = 0;
    for (int j = 0; j < 30; j++) begin
      if (avm_chipselect === 1'b1 && avm_write_n === 1'b0) begin
        wcycles++;
        total++;
        if (avm_writedata !== exp32 || avm_address !== 2'd0) begin
          bad++; $display("[TB] FAIL wait_hold: got addr=%0h data=%0h expected 0/%0h", avm_address, avm_writedata, exp32);
        end
      end else if (avm_chipselect === 1'b1) begin
        rcycles++;
      end
      @(negedge clk);
    end
    total++; if (wcycles !== wcfg + 1) begin bad++; $display("[TB] FAIL wait_wcycles: got %0d expected %0d", wcycles, wcfg + 1); end
    total++; if (rcycles !== rcfg + 1) begin bad++; $display("[TB] FAIL wait_rcycles: got %0d expected %0d", rcycles, rcfg + 1); end
    total++; if (wr_n - base_w !== 1) begin bad++; $display("[TB] FAIL wait_writes: got %0d expected 1", wr_n - base_w); end
    total++; if (rd_n - base_r !== 1) begin bad++; $display("[TB] FAIL wait_reads: got %0d expected 1", rd_n - base_r); end
    total++; if (wr_log[base_w] !== exp32) begin bad++; $display("[TB] FAIL wait_data: got %0h expected %0h", wr_log[base_w], exp32); end
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL wait_busy: got %b expected 0", busy); end
    total++; if (mismatch !== 1'b0) begin bad++; $display("[TB] FAIL wait_mismatch: got %b expected 0", mismatch); end
    wcfg = 0; rcfg = 0;
  endtask

  task automatic test_fault();
    int base;
    int expc;
    fault = 1'b1; mode = 2'd2; pattern_in = 18'h3FFFF; enable = 1'b1;
    wcfg = 0; rcfg = 0;
    do_reset();
    base = wr_n;
    for (int n = 1; n <= 300; n++) begin
      wait_writes(base + n, 20, "fault");
      wait_idle(10, "fault");
      expc = (n > 255) ? 255 : n;
      if (n <= 3 || n == 255 || n == 300) begin
        total++; if (mismatch !== 1'b1) begin bad++; $display("[TB] FAIL fault_flag%0d: got %b expected 1", n, mismatch); end
        total++; if (mismatch_count !== 8'(expc)) begin bad++; $display("[TB] FAIL fault_count%0d: got %0d expected %0d", n, mismatch_count, expc); end
      end
    end
  endtask

  task automatic test_reset_midop();
    int base_r;
    int base_w;
    int i;
    rcfg = 2;
    i = 0;
    @(negedge clk);
    while (!(avm_chipselect === 1'b1 && avm_write_n === 1'b1) && i < 30) begin
      @(negedge clk);
      i++;
    end
    total++;
    if (!(avm_chipselect === 1'b1 && avm_write_n === 1'b1)) begin
      bad++; $display("[TB] FAIL midop_read timeout: cs=%b write_n=%b expected 1/1", avm_chipselect, avm_write_n);
    end
    base_r = rd_n; base_w = wr_n;
    reset_n = 1'b0;
    @(negedge clk);
    total++; if (avm_chipselect !== 1'b0) begin bad++; $display("[TB] FAIL midop_cs: got %b expected 0", avm_chipselect); end
    total++; if (avm_write_n !== 1'b1) begin bad++; $display("[TB] FAIL midop_write_n: got %b expected 1", avm_write_n); end
    total++; if (avm_writedata !== 32'd0) begin bad++; $display("[TB] FAIL midop_wdata: got %0h expected 0", avm_writedata); end
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL midop_busy: got %b expected 0", busy); end
    total++; if (pattern !== 18'd0) begin bad++; $display("[TB] FAIL midop_pattern: got %0h expected 0", pattern); end
    total++; if (mismatch !== 1'b0) begin bad++; $display("[TB] FAIL midop_mismatch: got %b expected 0", mismatch); end
    total++; if (mismatch_count !== 8'd0) begin bad++; $display("[TB] FAIL midop_mcount: got %0d expected 0", mismatch_count); end
    @(negedge clk);
    total++; if (rd_n - base_r !== 0 || wr_n - base_w !== 0) begin bad++; $display("[TB] FAIL midop_bus: got reads=%0d writes=%0d expected 0/0", rd_n - base_r, wr_n - base_w); end
    reset_n = 1'b1;
    fault = 1'b0; rcfg = 0;
  endtask

  task automatic test_random();
    int base;
    int p;
    int m;
    int pin;
    int expv;
    enable = 1'b1; fault = 1'b0;
    p = 0;
    m = $urandom_range(0, 3);
    pin = int'($urandom_range(0, 262143));
    mode = 2'(m); pattern_in = 18'(pin);
    wcfg = 0; rcfg = 0;
    do_reset();
    base = wr_n;
    for (int k = 0; k < 30; k++) begin
      expv = next_pat(m, p, pin);
      wait_writes(base + k + 1, 40, "random");
      total++;
      if (wr_log[base + k] !== 32'(expv)) begin
        bad++; $display("[TB] FAIL random%0d mode%0d: got %0h expected %0h", k, m, wr_log[base + k], expv);
      end
      p = expv;
      m = $urandom_range(0, 3);
      pin = int'($urandom_range(0, 262143));
      mode = 2'(m); pattern_in = 18'(pin);
      wcfg = $urandom_range(0, 2); rcfg = $urandom_range(0, 2);
      hi_junk = 14'($urandom);
    end
    enable = 1'b0;
    wait_idle(20, "random");
    total++; if (pattern !== 18'(p)) begin bad++; $display("[TB] FAIL random_pattern: got %0h expected %0h", pattern, p); end
    total++; if (mismatch !== 1'b0) begin bad++; $display("[TB] FAIL random_mismatch: got %b expected 0", mismatch); end
    wcfg = 0; rcfg = 0;
  endtask

  initial begin
    test_reset();
    test_count();
    test_wrap();
    test_walk();
    test_waitrequest();
    test_fault();
    test_reset_midop();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/led_pattern_master.md
Name: led_pattern_master

Overview:
Avalon-MM master that sits directly upstream of the 18-bit LED PIO slave and drives its s1 port. On every tick of a programmable interval timer it generates the next LED pattern and writes it to PIO address 0. It then reads the register back, compares the result and records any mismatch. It replaces the Nios software loop that currently updates the LEDs.

Parameters:
PERIOD, 1000000, clocks between pattern updates (>=4); tick fires when the timer reaches PERIOD-1
WIDTH, 18, LED pattern width; must match the PIO port width

Ports:
clk  in  1  system clock
reset_n  in  1  synchronous, active-low reset
enable  in  1  1 = run the timer and issue updates; 0 = pause
mode  in  2  0 = binary up-count; 1 = walking one (rotate left); 2 = load pattern_in; 3 = hold (write the current pattern unchanged)
pattern_in  in  WIDTH  value used in mode 2
avm_address  out  2  always 0
avm_chipselect  out  1  transaction request
avm_write_n  out  1  0 = write, 1 = read
avm_writedata  out  32  {14'b0, pattern}
avm_readdata  in  32  read data; valid in the accept cycle (zero read latency)
avm_waitrequest  in  1  1 = stall; tie to 0 for the PIO
busy  out  1  high in any state other than IDLE
pattern  out  WIDTH  last pattern issued
mismatch  out  1  sticky flag, set on a readback compare failure
mismatch_count  out  8  saturating count of compare failures

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low on reset_n, sampled at the rising edge of clk.
- Reset values:
  - state = IDLE; timer = 0; pattern = 0.
  - avm_chipselect = 0; avm_write_n = 1; avm_address = 0; avm_writedata = 0.
  - busy = 0; mismatch = 0; mismatch_count = 0.
- Reset mid-transaction: the transaction is abandoned with no further bus activity. Outputs return to their reset values on the next edge.
- Timer:
  - Counts 0..PERIOD-1 only while enable=1 and state=IDLE; held at 0 when enable=0.
  - On reaching PERIOD-1, tick=1 for one cycle and the timer wraps to 0.
- FSM states: IDLE, WRITE, READ, CHECK.
- IDLE:
  - On tick, compute next_pattern from the mode sampled in that cycle.
  - mode 0: pattern+1, wrapping from 0x3FFFF to 0.
  - mode 1: rotate left by one. 0x20000 wraps to 0x00001. If pattern==0, next_pattern = 0x00001.
  - mode 2: pattern_in. mode 3: pattern.
  - Register pattern <= next_pattern and enter WRITE.
- WRITE:
  - Outputs: avm_chipselect=1, avm_write_n=0, avm_writedata={14'b0,pattern}.
  - Bus outputs are held stable while avm_waitrequest=1.
  - Accept cycle = the first cycle with avm_waitrequest=0; then go to READ.
  - Minimum write duration is 1 cycle.
- READ:
  - Outputs: avm_chipselect=1, avm_write_n=1.
  - In the accept cycle (waitrequest=0), capture avm_readdata[WIDTH-1:0] into rd_q and go to CHECK.
  - avm_readdata[31:WIDTH] is ignored.
- CHECK (one cycle):
  - avm_chipselect=0.
  - If rd_q != pattern: mismatch <= 1 and mismatch_count <= min(mismatch_count+1, 255).
  - Return to IDLE.
- Bus idle rule: chipselect is never asserted in IDLE or CHECK. WRITE to READ keeps chipselect high with write_n toggling; no idle cycle is required between them.
- Latency: the first write accept occurs 1 cycle after tick (zero-wait slave). tick to end of CHECK = 3 cycles. The next tick comes PERIOD cycles after the timer restarts in IDLE.
- enable falling during WRITE/READ/CHECK: the transaction completes normally and the FSM then stays in IDLE. Pattern state is preserved.
- mode or pattern_in changes outside IDLE have no effect until the next tick.
- mismatch and mismatch_count clear only on reset.
- busy = (state != IDLE), registered.

Test Plan:
- Reset and count, PERIOD=4, mode=0, zero-wait PIO model, enable=1: PIO register sequence 0x00001, 0x00002, 0x00003. Writes are 7 cycles apart (4 timer + W + R + C). mismatch stays 0.
- Count wrap: preload via mode 2 with pattern_in=0x3FFFF, then switch to mode=0. Next write is 0x00000 and writedata = 0x00000000.
- Walking one: mode=1 from reset. Writes are 0x00001, 0x00002, …, 0x20000, then wrap to 0x00001.
- Waitrequest: hold waitrequest=1 for 3 cycles in WRITE and 2 in READ. Address, writedata and write_n must stay stable throughout; exactly one write and one read are accepted.
- Readback fault: PIO model forces bit 5 low, mode 2 with pattern_in=0x3FFFF. mismatch=1 and mismatch_count increments by 1 per update. After 300 updates mismatch_count = 255 (saturated).
- Mid-op control: deassert enable in WRITE, then the transaction finishes and no further ticks occur. Assert reset_n=0 during READ: chipselect drops on the next edge and all outputs go to their reset values.
